// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture/crop block: FSM encoding,
// default geometry parameters and the sensor's VGA frame size.
package cam_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_ACTIVE  = 2'd2
    } cam_state_e;

    localparam int unsigned CAM_BPP_DEF  = 2;
    localparam int unsigned CAM_CW_DEF   = 10;
    localparam int unsigned CAM_FCW_DEF  = 16;

    localparam int unsigned OV7670_VGA_W = 640;
    localparam int unsigned OV7670_VGA_H = 480;

endpackage

// File: rtl/cam_edge_det.sv
// Rise/fall pulse detector: keeps a registered copy of the input and flags
// the cycle in which the input differs from its previous sample.
module cam_edge_det (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic d_q;

    // previous-sample history
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) d_q <= 1'b0;
        else         d_q <= i_d;
    end

    assign o_rise = i_d & ~d_q;
    assign o_fall = ~i_d & d_q;

endmodule

// File: rtl/cam_capture_crop.sv
// OV7670 byte-stream capture: frame sync FSM, pixel assembly, crop window
// and optional 2:1 decimation, with a 2-cycle write pipeline to a FIFO.
module cam_capture_crop
    import cam_pkg::*;
#(
    parameter int unsigned BPP = CAM_BPP_DEF,
    parameter int unsigned CW  = CAM_CW_DEF,
    parameter int unsigned FCW = CAM_FCW_DEF
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_cfg_done,
    input  logic               i_vsync,
    input  logic               i_href,
    input  logic [7:0]         i_data,
    input  logic [CW-1:0]      i_crop_x0,
    input  logic [CW-1:0]      i_crop_y0,
    input  logic [CW-1:0]      i_crop_w,
    input  logic [CW-1:0]      i_crop_h,
    input  logic               i_decim,
    input  logic               i_full,
    input  logic               i_clr_status,
    output logic               o_wr,
    output logic [8*BPP-1:0]   o_wdata,
    output logic               o_sof,
    output logic               o_eof,
    output logic               o_ovf,
    output logic [FCW-1:0]     o_frame_cnt,
    output logic               o_busy
);

    localparam int unsigned PW      = 8 * BPP;
    localparam logic [1:0]  LAST_PH = 2'(BPP - 1);

    cam_state_e     state_q, state_d;
    logic           vs_q, href_q;
    logic [7:0]     data_q;
    logic [CW-1:0]  x_q, x_d, y_q, y_d;
    logic [1:0]     phase_q, phase_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  sh_x0_q, sh_x0_d, sh_y0_q, sh_y0_d;
    logic [CW-1:0]  sh_w_q, sh_w_d, sh_h_q, sh_h_d;
    logic           sh_decim_q, sh_decim_d;
    logic           pix_vld_q, pix_vld_d;
    logic           wr_q, wr_d;
    logic [PW-1:0]  wdata_q, wdata_d;
    logic           sof_q, sof_d;
    logic           ovf_q, ovf_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    logic vs_rise, vs_fall, hs_fall, hs_rise_unused;
    logic frame_start, frame_end, active, last_b, in_win, dec_ok;
    logic [PW-1:0] asm_w;
    logic [CW:0]   xe, ye, x_beg, y_beg, x_end, y_end;

    cam_edge_det u_vs_edge (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (vs_q),
        .o_rise (vs_rise),
        .o_fall (vs_fall)
    );

    cam_edge_det u_hs_edge (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (href_q),
        .o_rise (hs_rise_unused),
        .o_fall (hs_fall)
    );

    // sensor input register stage
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vs_q   <= 1'b0;
            href_q <= 1'b0;
            data_q <= '0;
        end else begin
            vs_q   <= i_vsync;
            href_q <= i_href;
            data_q <= i_data;
        end
    end

    // frame FSM next state; dropping cfg_done aborts from any state
    always_comb begin
        state_d = state_q;
        if (!i_cfg_done) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_WAIT_VS;
                S_WAIT_VS: if (vs_fall) state_d = S_ACTIVE;
                S_ACTIVE:  if (vs_rise) state_d = S_WAIT_VS;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    assign frame_start = (state_q == S_WAIT_VS) && (state_d == S_ACTIVE);
    assign frame_end   = (state_q == S_ACTIVE)  && (state_d == S_WAIT_VS);
    assign active      = (state_q == S_ACTIVE);
    assign last_b      = (phase_q == LAST_PH);

    // first byte ends up in the MSBs after BPP shifts
    assign asm_w = (acc_q << 8) | PW'(data_q);

    assign xe    = {1'b0, x_q};
    assign ye    = {1'b0, y_q};
    assign x_beg = {1'b0, sh_x0_q};
    assign y_beg = {1'b0, sh_y0_q};
    assign x_end = x_beg + {1'b0, sh_w_q};
    assign y_end = y_beg + {1'b0, sh_h_q};
    assign in_win = (xe >= x_beg) && (xe < x_end) && (ye >= y_beg) && (ye < y_end);
    assign dec_ok = !sh_decim_q || (!x_q[0] && !y_q[0]);

    // pixel assembly, position counters, shadow crop and write pipeline
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        phase_d    = '0;
        acc_d      = acc_q;
        pix_vld_d  = 1'b0;
        sh_x0_d    = sh_x0_q;
        sh_y0_d    = sh_y0_q;
        sh_w_d     = sh_w_q;
        sh_h_d     = sh_h_q;
        sh_decim_d = sh_decim_q;

        if (!href_q) begin
            x_d = '0;
        end else if (active) begin
            acc_d   = asm_w;
            phase_d = last_b ? 2'd0 : phase_q + 2'd1;
            if (last_b) begin
                pix_vld_d = in_win && dec_ok;
                x_d       = (x_q == '1) ? x_q : x_q + 1'b1;
            end
        end

        if (frame_start) begin
            y_d        = '0;
            sh_x0_d    = i_crop_x0;
            sh_y0_d    = i_crop_y0;
            sh_w_d     = i_crop_w;
            sh_h_d     = i_crop_h;
            sh_decim_d = i_decim;
        end else if (active && hs_fall) begin
            y_d = (y_q == '1) ? y_q : y_q + 1'b1;
        end

        // acc_q still holds the qualified pixel here; gating on the next
        // state keeps o_wr low in the first cycle after leaving ACTIVE
        wr_d    = pix_vld_q && !i_full && (state_d == S_ACTIVE);
        wdata_d = wr_d ? acc_q : wdata_q;
        if (pix_vld_q && i_full && (state_d == S_ACTIVE)) ovf_d = 1'b1;
        else if (i_clr_status)                            ovf_d = 1'b0;
        else                                              ovf_d = ovf_q;

        sof_d  = frame_start;
        fcnt_d = frame_end ? fcnt_q + 1'b1 : fcnt_q;
    end

    // state and datapath registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            phase_q    <= '0;
            acc_q      <= '0;
            sh_x0_q    <= '0;
            sh_y0_q    <= '0;
            sh_w_q     <= '0;
            sh_h_q     <= '0;
            sh_decim_q <= 1'b0;
            pix_vld_q  <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            sof_q      <= 1'b0;
            ovf_q      <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            sh_x0_q    <= sh_x0_d;
            sh_y0_q    <= sh_y0_d;
            sh_w_q     <= sh_w_d;
            sh_h_q     <= sh_h_d;
            sh_decim_q <= sh_decim_d;
            pix_vld_q  <= pix_vld_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            sof_q      <= sof_d;
            ovf_q      <= ovf_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // o_sof is registered (first ACTIVE cycle); o_eof is decoded from the
    // exit condition so it also falls inside the last ACTIVE cycle
    assign o_wr        = wr_q;
    assign o_wdata     = wdata_q;
    assign o_sof       = sof_q;
    assign o_eof       = frame_end;
    assign o_ovf       = ovf_q;
    assign o_frame_cnt = fcnt_q;
    assign o_busy      = active;

endmodule

// File: tb/tb_cam_capture_crop.sv
// Directed bench: a BPP=2 and a BPP=1 instance share one synthetic OV7670
// stream; writes are collected into queues and checked after each frame.
module tb_cam_capture_crop;

    logic        clk = 1'b0;
    logic        rstn, cfg_done, vsync, href, decim, full, clr;
    logic [7:0]  data;
    logic [9:0]  cx0, cy0, cw, ch;

    logic        wr0, sof0, eof0, ovf0, busy0;
    logic [15:0] wdata0, fcnt0;
    logic        wr1, sof1, eof1, ovf1, busy1;
    logic [7:0]  wdata1;
    logic [15:0] fcnt1;

    logic [15:0] q0[$];
    logic [7:0]  q1[$];
    int sof_n = 0, eof_n = 0;
    int passed = 0, total = 0, fails = 0;
    int b0, b1, s0, e0;

    always #5 clk = ~clk;

    cam_capture_crop #(.BPP(2), .CW(10), .FCW(16)) u_dut (
        .i_clk(clk), .i_rstn(rstn), .i_cfg_done(cfg_done), .i_vsync(vsync),
        .i_href(href), .i_data(data), .i_crop_x0(cx0), .i_crop_y0(cy0),
        .i_crop_w(cw), .i_crop_h(ch), .i_decim(decim), .i_full(full),
        .i_clr_status(clr), .o_wr(wr0), .o_wdata(wdata0), .o_sof(sof0),
        .o_eof(eof0), .o_ovf(ovf0), .o_frame_cnt(fcnt0), .o_busy(busy0)
    );

    cam_capture_crop #(.BPP(1), .CW(10), .FCW(16)) u_dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_cfg_done(cfg_done), .i_vsync(vsync),
        .i_href(href), .i_data(data), .i_crop_x0(cx0), .i_crop_y0(cy0),
        .i_crop_w(cw), .i_crop_h(ch), .i_decim(decim), .i_full(full),
        .i_clr_status(clr), .o_wr(wr1), .o_wdata(wdata1), .o_sof(sof1),
        .o_eof(eof1), .o_ovf(ovf1), .o_frame_cnt(fcnt1), .o_busy(busy1)
    );

    // collect write strobes and frame pulses
    always @(negedge clk) begin
        if (wr0)  q0.push_back(wdata0);
        if (wr1)  q1.push_back(wdata1);
        if (sof0) sof_n++;
        if (eof0) eof_n++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_val(input int mode, input int l, input int k);
        if (mode == 0)      return (k % 2 == 1) ? 8'hCD : 8'hAB;
        else if (mode == 1) return (k % 2 == 1) ? 8'(k / 2) : 8'(l);
        else                return 8'((l % 16) * 16 + (k % 16));
    endfunction

    task automatic set_crop(input logic [9:0] x0, input logic [9:0] y0,
                            input logic [9:0] w, input logic [9:0] h);
        cx0 = x0; cy0 = y0; cw = w; ch = h;
    endtask

    // one frame: vsync falls, nl lines of nb bytes, vsync rises;
    // optional full window on line 0, cfg_done drop, mid-frame crop change
    task automatic run_frame(input int nl, input int nb, input int mode,
                             input int flo, input int fhi,
                             input int drop_line, input int crop_line);
        @(negedge clk); vsync = 1'b0; href = 1'b0; data = 8'h00;
        repeat (3) @(negedge clk);
        for (int l = 0; l < nl; l++) begin
            for (int k = 0; k < nb; k++) begin
                @(negedge clk);
                href = 1'b1;
                data = byte_val(mode, l, k);
                full = (l == 0) && (k >= flo) && (k <= fhi);
                if (l == drop_line && k == 4)     cfg_done = 1'b0;
                if (l == drop_line + 1 && k == 0) cfg_done = 1'b1;
                if (l == crop_line && k == 0)     set_crop(10'd0, 10'd0, 10'd640, 10'd480);
            end
            @(negedge clk); href = 1'b0; data = 8'h00; full = 1'b0;
            repeat (3) @(negedge clk);
        end
        @(negedge clk); vsync = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic mark();
        b0 = q0.size(); b1 = q1.size(); s0 = sof_n; e0 = eof_n;
    endtask

    initial begin
        rstn = 1'b0; cfg_done = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'h00;
        decim = 1'b0; full = 1'b0; clr = 1'b0;
        set_crop(10'd0, 10'd0, 10'd640, 10'd480);
        repeat (3) @(negedge clk);

        chk("rst_wr",    32'(wr0),    32'h0);
        chk("rst_wdata", 32'(wdata0), 32'h0);
        chk("rst_sof",   32'(sof0),   32'h0);
        chk("rst_eof",   32'(eof0),   32'h0);
        chk("rst_ovf",   32'(ovf0),   32'h0);
        chk("rst_fcnt",  32'(fcnt0),  32'h0);
        chk("rst_busy",  32'(busy0),  32'h0);

        @(negedge clk); rstn = 1'b1;
        @(negedge clk); cfg_done = 1'b1;
        repeat (2) @(negedge clk);

        // full window, two frames of constant 0xAB,0xCD pixels
        mark();
        run_frame(4, 16, 0, -1, -2, -5, -5);
        run_frame(4, 16, 0, -1, -2, -5, -5);
        chk("full_cnt",   q0.size() - b0, 32'd64);
        chk("full_data",  32'(q0[$]),     32'hABCD);
        chk("full_fcnt",  32'(fcnt0),     32'd2);
        chk("full_sof",   sof_n - s0,     32'd2);
        chk("full_eof",   eof_n - e0,     32'd2);
        chk("bpp1_cnt",   q1.size() - b1, 32'd128);
        chk("bpp1_data",  32'(q1[$]),     32'hCD);

        // crop window 10,5 size 4x3
        set_crop(10'd10, 10'd5, 10'd4, 10'd3);
        mark();
        run_frame(10, 32, 1, -1, -2, -5, -5);
        chk("crop_cnt",   q0.size() - b0, 32'd12);
        chk("crop_first", 32'(q0[b0]),    32'h050A);
        chk("crop_last",  32'(q0[$]),     32'h070D);
        chk("crop_fcnt",  32'(fcnt0),     32'd3);

        // 2:1 decimation on an 8x4 frame
        set_crop(10'd0, 10'd0, 10'd8, 10'd4);
        decim = 1'b1;
        mark();
        run_frame(4, 16, 1, -1, -2, -5, -5);
        decim = 1'b0;
        chk("dec_cnt",    q0.size() - b0, 32'd8);
        chk("dec_first",  32'(q0[b0]),    32'h0000);
        chk("dec_second", 32'(q0[b0+1]),  32'h0002);
        chk("dec_last",   32'(q0[$]),     32'h0206);

        // downstream full for three qualifying pixels
        set_crop(10'd0, 10'd0, 10'd8, 10'd2);
        chk("ovf_pre",    32'(ovf0),      32'h0);
        mark();
        run_frame(2, 16, 1, 7, 12, -5, -5);
        chk("ovf_cnt",    q0.size() - b0, 32'd13);
        chk("ovf_last",   32'(q0[$]),     32'h0107);
        chk("ovf_set",    32'(ovf0),      32'h1);
        repeat (2) @(negedge clk);
        chk("ovf_sticky", 32'(ovf0),      32'h1);
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("ovf_clr",    32'(ovf0),      32'h0);

        // cfg_done dropped on line 1, raised again on line 2
        set_crop(10'd0, 10'd0, 10'd640, 10'd480);
        mark();
        run_frame(4, 16, 1, -1, -2, 1, -5);
        chk("abort_cnt",  q0.size() - b0, 32'd9);
        chk("abort_eof",  eof_n - e0,     32'd0);
        chk("abort_fcnt", 32'(fcnt0),     32'd5);
        chk("abort_busy", 32'(busy0),     32'h0);
        mark();
        run_frame(4, 16, 1, -1, -2, -5, -5);
        chk("recap_cnt",  q0.size() - b0, 32'd32);
        chk("recap_last", 32'(q0[$]),     32'h0307);
        chk("recap_fcnt", 32'(fcnt0),     32'd6);

        // zero-width window
        set_crop(10'd0, 10'd0, 10'd0, 10'd480);
        mark();
        run_frame(4, 16, 1, -1, -2, -5, -5);
        chk("w0_cnt",     q0.size() - b0, 32'd0);
        chk("w0_sof",     sof_n - s0,     32'd1);
        chk("w0_eof",     eof_n - e0,     32'd1);
        chk("w0_fcnt",    32'(fcnt0),     32'd7);

        // odd byte count, crop changed on line 1 of the first frame
        set_crop(10'd1, 10'd1, 10'd3, 10'd2);
        mark();
        run_frame(4, 7, 2, -1, -2, -5, 1);
        chk("mid_b1_cnt",   q1.size() - b1, 32'd6);
        chk("mid_b1_first", 32'(q1[b1]),    32'h11);
        chk("mid_b1_last",  32'(q1[$]),     32'h23);
        chk("mid_b2_cnt",   q0.size() - b0, 32'd4);
        chk("mid_b2_last",  32'(q0[$]),     32'h2425);
        mark();
        run_frame(4, 7, 2, -1, -2, -5, -5);
        chk("nxt_b1_cnt",   q1.size() - b1, 32'd28);
        chk("nxt_b1_first", 32'(q1[b1]),    32'h00);
        chk("nxt_b1_last",  32'(q1[$]),     32'h36);
        chk("nxt_b2_cnt",   q0.size() - b0, 32'd12);
        chk("nxt_b2_last",  32'(q0[$]),     32'h3435);
        chk("nxt_fcnt",     32'(fcnt0),     32'd9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
